// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
//   trap_state_type    : sequencer states
//   cause_m*           : mcause codes for the three machine interrupts
//   trap_ctrl_in_type  : execute/retire and CSR-side inputs, bundled
//   trap_ctrl_out_type : strobes and trap details towards CSR file and fetch
//   irq_cause()        : fixed-priority cause selection, ext > sw > tim
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP,
    ST_MRET,
    ST_REDIRECT
  } trap_state_type;

  localparam logic [3:0] cause_mei = 4'd11;
  localparam logic [3:0] cause_msi = 4'd3;
  localparam logic [3:0] cause_mti = 4'd7;

  typedef struct packed {
    logic        mstatus_mie;
    logic [2:0]  mie_en;      // {ext, sw, tim}
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_req;
    logic [31:0] next_pc;
    logic        pipe_idle;
  } trap_ctrl_in_type;

  typedef struct packed {
    logic [2:0]  irq_pend;    // {ext, sw, tim}
    logic        stall;
    logic        trap_valid;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        trap_intr;
    logic        mret_valid;
    logic        redirect;
    logic        redirect_mret;
  } trap_ctrl_out_type;

  // Argument is the enabled pending vector {ext, sw, tim}.
  function automatic logic [3:0] irq_cause(input logic [2:0] irq);
    logic [3:0] cause;
    cause = cause_mti;
    if (irq[2])      cause = cause_mei;
    else if (irq[1]) cause = cause_msi;
    return cause;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// N-stage level synchroniser for one asynchronous interrupt line.
//   clk      : destination clock
//   rst      : asynchronous active-low reset, clears all stages
//   i_async  : raw asynchronous level
//   o_sync   : level after STAGES flops
module irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer.
// Synchronises MEI/MSI/MTI, arbitrates them against synchronous exceptions
// and mret, drains the pipeline for interrupts and issues one-cycle
// trap/mret strobes followed by a one-cycle fetch redirect.
//   clk, rst                    : clock, async active-low reset
//   irq_ext/irq_sw/irq_tim      : raw interrupt levels
//   mstatus_mie, mie_en         : global and per-line enables {ext,sw,tim}
//   exc_req/cause/pc/tval       : synchronous exception from execute
//   mret_req                    : mret in execute
//   next_pc, pipe_idle          : oldest unretired PC, pipeline empty
//   irq_pend                    : synchronised levels for mip
//   stall                       : hold fetch/issue
//   trap_valid/cause/epc/tval/intr : trap strobe and details for CSR file
//   mret_valid                  : mret strobe for CSR file
//   redirect, redirect_mret     : fetch load, 1 = mepc, 0 = mtvec
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_tim,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie_en,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic [31:0] next_pc,
  input  logic        pipe_idle,
  output logic [2:0]  irq_pend,
  output logic        stall,
  output logic        trap_valid,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_tval,
  output logic        trap_intr,
  output logic        mret_valid,
  output logic        redirect,
  output logic        redirect_mret
);

  trap_ctrl_in_type  w_in;
  trap_ctrl_out_type w_out;
  logic [2:0]        w_pend;
  logic [2:0]        w_irq_act;
  logic              w_irq_en;

  trap_state_type    r_state;
  logic [3:0]        r_cause;
  logic [31:0]       r_epc;
  logic [31:0]       r_tval;
  logic              r_intr;
  logic              r_redir_mret;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .rst(rst), .i_async(irq_ext), .o_sync(w_pend[2]));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .rst(rst), .i_async(irq_sw),  .o_sync(w_pend[1]));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tim (
    .clk(clk), .rst(rst), .i_async(irq_tim), .o_sync(w_pend[0]));

  assign w_in = '{mstatus_mie: mstatus_mie, mie_en: mie_en,
                  exc_req: exc_req, exc_cause: exc_cause, exc_pc: exc_pc,
                  exc_tval: exc_tval, mret_req: mret_req, next_pc: next_pc,
                  pipe_idle: pipe_idle};

  assign w_irq_act = w_pend & w_in.mie_en;
  assign w_irq_en  = w_in.mstatus_mie & (|w_irq_act);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cause      <= '0;
      r_epc        <= '0;
      r_tval       <= '0;
      r_intr       <= 1'b0;
      r_redir_mret <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in.exc_req) begin
            r_state      <= ST_TRAP;
            r_cause      <= w_in.exc_cause;
            r_epc        <= w_in.exc_pc;
            r_tval       <= w_in.exc_tval;
            r_intr       <= 1'b0;
            r_redir_mret <= 1'b0;
          end else if (w_in.mret_req) begin
            r_state      <= ST_MRET;
            r_redir_mret <= 1'b1;
          end else if (w_irq_en) begin
            // Cause is committed here; later enable/line changes are ignored.
            r_state      <= ST_DRAIN;
            r_cause      <= irq_cause(w_irq_act);
            r_tval       <= '0;
            r_intr       <= 1'b1;
            r_redir_mret <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_in.exc_req) begin
            r_state <= ST_TRAP;
            r_cause <= w_in.exc_cause;
            r_epc   <= w_in.exc_pc;
            r_tval  <= w_in.exc_tval;
            r_intr  <= 1'b0;
          end else if (w_in.pipe_idle) begin
            r_state <= ST_TRAP;
            r_epc   <= w_in.next_pc;
          end
        end
        ST_TRAP:     r_state <= ST_REDIRECT;
        ST_MRET:     r_state <= ST_REDIRECT;
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out               = '0;
    w_out.irq_pend      = w_pend;
    w_out.stall         = (r_state != ST_IDLE);
    w_out.trap_valid    = (r_state == ST_TRAP);
    w_out.mret_valid    = (r_state == ST_MRET);
    w_out.redirect      = (r_state == ST_REDIRECT);
    w_out.redirect_mret = (r_state == ST_REDIRECT) & r_redir_mret;
    w_out.trap_cause    = r_cause;
    w_out.trap_epc      = r_epc;
    w_out.trap_tval     = r_tval;
    w_out.trap_intr     = r_intr;
  end

  assign irq_pend      = w_out.irq_pend;
  assign stall         = w_out.stall;
  assign trap_valid    = w_out.trap_valid;
  assign trap_cause    = w_out.trap_cause;
  assign trap_epc      = w_out.trap_epc;
  assign trap_tval     = w_out.trap_tval;
  assign trap_intr     = w_out.trap_intr;
  assign mret_valid    = w_out.mret_valid;
  assign redirect      = w_out.redirect;
  assign redirect_mret = w_out.redirect_mret;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: scenario tasks with randomized data,
// expectations derived from the trap sequencing and priority rules.
module tb_trap_ctrl;

  localparam int SYNC = 2;

  logic        rst, clk;
  logic        irq_ext, irq_sw, irq_tim;
  logic        mstatus_mie;
  logic [2:0]  mie_en;
  logic        exc_req;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_req;
  logic [31:0] next_pc;
  logic        pipe_idle;
  logic [2:0]  irq_pend;
  logic        stall, trap_valid, trap_intr, mret_valid, redirect, redirect_mret;
  logic [3:0]  trap_cause;
  logic [31:0] trap_epc, trap_tval;

  int n_pass = 0;
  int n_total = 0;

  trap_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .rst(rst), .clk(clk),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_tim(irq_tim),
    .mstatus_mie(mstatus_mie), .mie_en(mie_en),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .next_pc(next_pc), .pipe_idle(pipe_idle),
    .irq_pend(irq_pend), .stall(stall), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .trap_intr(trap_intr), .mret_valid(mret_valid),
    .redirect(redirect), .redirect_mret(redirect_mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, trap_valid, mret_valid, redirect, redirect_mret}
  logic [4:0]  ctl;
  logic [68:0] fields;
  logic [76:0] all_out;
  assign ctl     = {stall, trap_valid, mret_valid, redirect, redirect_mret};
  assign fields  = {trap_intr, trap_cause, trap_epc, trap_tval};
  assign all_out = {irq_pend, ctl, fields};

  // Highest-priority enabled line: ext(11) > sw(3) > tim(7).
  function automatic logic [3:0] model_cause(input logic [2:0] act);
    logic [3:0] tbl [3];
    logic [3:0] res;
    logic       found;
    tbl[0] = 4'd11; tbl[1] = 4'd3; tbl[2] = 4'd7;
    res = 4'd0; found = 1'b0;
    for (int i = 0; i < 3; i++)
      if (!found && act[2-i]) begin res = tbl[i]; found = 1'b1; end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {irq_ext, irq_sw, irq_tim} = 3'b000;
    mstatus_mie = 1'b0; mie_en = 3'b000;
    exc_req = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_req = 1'b0; next_pc = '0; pipe_idle = 1'b0;
    tick(); tick();
    n_total++;
    if (all_out !== 77'b0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if (all_out !== 77'b0) $display("FAIL post_reset_outputs: got %h want 0", all_out);
    else n_pass++;
  endtask

  task automatic test_exception();
    logic [3:0]  c;
    logic [31:0] pc, tv;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin c = 4'd2; pc = 32'h100; tv = 32'hDEAD; end
      else begin c = 4'($urandom_range(0, 15)); pc = $urandom; tv = $urandom; end
      exc_req = 1'b1; exc_cause = c; exc_pc = pc; exc_tval = tv;
      tick();
      exc_req = 1'b0; exc_cause = 4'($urandom); exc_pc = $urandom; exc_tval = $urandom;
      n_total++;
      if (ctl !== 5'b11000) $display("FAIL exc_trap_ctl[%0d]: got %b want 11000", i, ctl);
      else n_pass++;
      n_total++;
      if (fields !== {1'b0, c, pc, tv})
        $display("FAIL exc_fields[%0d]: got %h want %h", i, fields, {1'b0, c, pc, tv});
      else n_pass++;
      tick();
      n_total++;
      if (ctl !== 5'b10010) $display("FAIL exc_redirect_ctl[%0d]: got %b want 10010", i, ctl);
      else n_pass++;
      n_total++;
      if (fields !== {1'b0, c, pc, tv})
        $display("FAIL exc_fields_stable[%0d]: got %h want %h", i, fields, {1'b0, c, pc, tv});
      else n_pass++;
      tick();
      n_total++;
      if (ctl !== 5'b00000) $display("FAIL exc_idle_ctl[%0d]: got %b want 00000", i, ctl);
      else n_pass++;
    end
  endtask

  task automatic test_interrupt_drain();
    logic [2:0]  lines, en;
    logic [3:0]  ecause;
    logic [31:0] npc;
    int          d;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin lines = 3'b101; en = 3'b111; d = 3; end
      else begin
        lines = 3'($urandom_range(1, 7));
        en    = 3'($urandom_range(0, 7));
        if ((lines & en) == 3'b000) en = en | lines;
        d = $urandom_range(0, 4);
      end
      ecause = model_cause(lines & en);
      mstatus_mie = 1'b1; mie_en = en; pipe_idle = 1'b0;
      {irq_ext, irq_sw, irq_tim} = lines;
      repeat (SYNC) tick();
      n_total++;
      if ({irq_pend, stall} !== {lines, 1'b0})
        $display("FAIL irq_sync[%0d]: got %b want %b", t, {irq_pend, stall}, {lines, 1'b0});
      else n_pass++;
      tick();
      n_total++;
      if (ctl !== 5'b10000) $display("FAIL drain_entry[%0d]: got %b want 10000", t, ctl);
      else n_pass++;
      // Withdrawing the request after entry must not cancel the trap.
      {irq_ext, irq_sw, irq_tim} = 3'b000;
      if (t != 0) begin mstatus_mie = 1'($urandom); mie_en = 3'($urandom); end
      for (int k = 0; k < d; k++) begin
        tick();
        n_total++;
        if (ctl !== 5'b10000) $display("FAIL drain_hold[%0d.%0d]: got %b want 10000", t, k, ctl);
        else n_pass++;
      end
      npc = $urandom; pipe_idle = 1'b1; next_pc = npc;
      tick();
      pipe_idle = 1'b0; next_pc = $urandom;
      n_total++;
      if (ctl !== 5'b11000) $display("FAIL irq_trap_ctl[%0d]: got %b want 11000", t, ctl);
      else n_pass++;
      n_total++;
      if (fields !== {1'b1, ecause, npc, 32'h0})
        $display("FAIL irq_fields[%0d]: got %h want %h", t, fields, {1'b1, ecause, npc, 32'h0});
      else n_pass++;
      mstatus_mie = 1'b1;
      tick();
      n_total++;
      if (ctl !== 5'b10010) $display("FAIL irq_redirect[%0d]: got %b want 10010", t, ctl);
      else n_pass++;
      tick();
      n_total++;
      if (ctl !== 5'b00000) $display("FAIL irq_idle[%0d]: got %b want 00000", t, ctl);
      else n_pass++;
    end
  endtask

  task automatic test_exc_in_drain();
    logic [31:0] pc, tv;
    pc = $urandom; tv = $urandom;
    mstatus_mie = 1'b1; mie_en = 3'b111; pipe_idle = 1'b0;
    irq_ext = 1'b1;
    repeat (SYNC + 1) tick();
    n_total++;
    if (ctl !== 5'b10000) $display("FAIL xdrain_entry: got %b want 10000", ctl);
    else n_pass++;
    irq_ext = 1'b0;
    exc_req = 1'b1; exc_cause = 4'd5; exc_pc = pc; exc_tval = tv;
    pipe_idle = 1'($urandom); next_pc = $urandom;
    tick();
    exc_req = 1'b0; pipe_idle = 1'b0;
    n_total++;
    if (ctl !== 5'b11000) $display("FAIL xdrain_trap_ctl: got %b want 11000", ctl);
    else n_pass++;
    n_total++;
    if (fields !== {1'b0, 4'd5, pc, tv})
      $display("FAIL xdrain_fields: got %h want %h", fields, {1'b0, 4'd5, pc, tv});
    else n_pass++;
    tick();
    n_total++;
    if (ctl !== 5'b10010) $display("FAIL xdrain_redirect: got %b want 10010", ctl);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (ctl !== 5'b00000) $display("FAIL xdrain_no_retrap[%0d]: got %b want 00000", k, ctl);
      else n_pass++;
    end
  endtask

  task automatic test_mret_irq();
    logic [31:0] npc;
    mstatus_mie = 1'b1; mie_en = 3'b111; pipe_idle = 1'b0;
    irq_tim = 1'b1;
    repeat (SYNC) tick();
    mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    n_total++;
    if (ctl !== 5'b10100) $display("FAIL mret_valid: got %b want 10100", ctl);
    else n_pass++;
    tick();
    n_total++;
    if (ctl !== 5'b10011) $display("FAIL mret_redirect: got %b want 10011", ctl);
    else n_pass++;
    tick();
    n_total++;
    if (ctl !== 5'b00000) $display("FAIL mret_idle: got %b want 00000", ctl);
    else n_pass++;
    tick();
    n_total++;
    if (ctl !== 5'b10000) $display("FAIL mret_then_drain: got %b want 10000", ctl);
    else n_pass++;
    irq_tim = 1'b0;
    npc = $urandom; next_pc = npc; pipe_idle = 1'b1;
    tick();
    pipe_idle = 1'b0;
    n_total++;
    if ({ctl, fields} !== {5'b11000, 1'b1, 4'd7, npc, 32'h0})
      $display("FAIL mret_irq_trap: got %h want %h", {ctl, fields}, {5'b11000, 1'b1, 4'd7, npc, 32'h0});
    else n_pass++;
    tick(); tick();
    n_total++;
    if (ctl !== 5'b00000) $display("FAIL mret_irq_idle: got %b want 00000", ctl);
    else n_pass++;
  endtask

  task automatic test_irq_masked();
    mstatus_mie = 1'b0; mie_en = 3'b111;
    irq_sw = 1'b1;
    tick();
    irq_sw = 1'b0;
    n_total++;
    if ({irq_pend, ctl} !== {3'b000, 5'b00000})
      $display("FAIL masked_stage1: got %b want 00000000", {irq_pend, ctl});
    else n_pass++;
    tick();
    n_total++;
    if ({irq_pend, ctl} !== {3'b010, 5'b00000})
      $display("FAIL masked_pend: got %b want 01000000", {irq_pend, ctl});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({irq_pend, ctl} !== 8'b0)
        $display("FAIL masked_no_trap[%0d]: got %b want 00000000", k, {irq_pend, ctl});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    mstatus_mie = 1'b1; mie_en = 3'b111; pipe_idle = 1'b0;
    irq_ext = 1'b1;
    repeat (SYNC + 1) tick();
    n_total++;
    if (ctl !== 5'b10000) $display("FAIL rstdrain_entry: got %b want 10000", ctl);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (all_out !== 77'b0) $display("FAIL rstdrain_async: got %h want 0", all_out);
    else n_pass++;
    irq_ext = 1'b0; pipe_idle = 1'b1;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (all_out !== 77'b0) $display("FAIL rstdrain_quiet[%0d]: got %h want 0", k, all_out);
      else n_pass++;
    end
    pipe_idle = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exception();
    test_interrupt_drain();
    test_exc_in_drain();
    test_mret_irq();
    test_irq_masked();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the machine-mode CSR file. It synchronises the three machine interrupt lines and arbitrates them against synchronous exceptions and `mret`. It stalls and drains the pipeline for interrupts, then issues the single-cycle exception/mret strobes that the CSR file consumes. It sits between execute/retire and the CSR file, and drives the fetch redirect to `mtvec`/`mepc`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop stages per interrupt line, legal range 2..4.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `rst` in 1: asynchronous, active-low reset.
- `clk` in 1: the only clock.
- `irq_ext`, `irq_sw`, `irq_tim` in 1 each: raw asynchronous level interrupt lines (MEI, MSI, MTI).
- `mstatus_mie` in 1: `mstatus[3]` from the CSR file.
- `mie_en` in 3: `{mie[11], mie[3], mie[7]}`, i.e. the enables for {ext, sw, tim}.
- `exc_req` in 1: synchronous exception from execute, valid for one cycle.
- `exc_cause` in 4, `exc_pc` in 32, `exc_tval` in 32: exception details, qualified by `exc_req`.
- `mret_req` in 1: `mret` in execute.
- `next_pc` in 32: PC of the oldest unretired instruction; valid when `pipe_idle=1`.
- `pipe_idle` in 1: no instruction in flight past fetch.
- `irq_pend` out 3: synchronised {ext, sw, tim} levels, feeding `mip`.
- `stall` out 1: holds fetch and issue.
- `trap_valid` out 1: feeds the CSR `exception` input.
- `trap_cause` out 4, `trap_epc` out 32, `trap_tval` out 32: trap details for the CSR file.
- `trap_intr` out 1: the trap is an interrupt (mcause[31]).
- `mret_valid` out 1: feeds the CSR `mret` input.
- `redirect` out 1: fetch loads `mtvec`/`mepc` this cycle.
- `redirect_mret` out 1: 1 selects `mepc`, 0 selects `mtvec`.

## Operation
- Enabled pending interrupt: `irq_en = mstatus_mie & |(irq_pend & mie_en)`.
- Interrupt priority: ext (cause 11) > sw (cause 3) > tim (cause 7).
- FSM states: IDLE, DRAIN, TRAP, MRET, REDIRECT.
- **IDLE**
  - `exc_req` → TRAP. Latch `exc_cause`, `exc_pc`, `exc_tval`; set `intr=0`.
  - Else `mret_req` → MRET.
  - Else `irq_en` → DRAIN. Latch the winning cause; set `intr=1`, `tval=0`.
  - Priority: exception > mret > interrupt.
- **DRAIN**
  - `exc_req` has priority: it overwrites the latched fields with exception data, clears `intr`, and goes to TRAP.
  - Else `pipe_idle` → TRAP, latching `epc=next_pc`.
  - The interrupt cause is committed once DRAIN is entered. Deassertion of the line, `mie`, or `mstatus_mie` during DRAIN does not cancel the trap.
  - DRAIN has no timeout.
- **TRAP**: `trap_valid=1` for exactly one cycle, then REDIRECT with `redirect_mret=0`.
- **MRET**: `mret_valid=1` for exactly one cycle, then REDIRECT with `redirect_mret=1`.
- **REDIRECT**: `redirect=1` for one cycle → IDLE.
  - The CSR file has committed `mcause`/`mepc` and `mstatus` by this cycle, so `mtvec` vectoring and `mepc` are already updated.
- `stall = 1` in DRAIN, TRAP, MRET, REDIRECT; 0 in IDLE.
- `exc_req`/`mret_req` arriving in TRAP, MRET or REDIRECT are ignored. The pipeline is stalled then, so execute must not present them.
- Simultaneous `mret_req` and `irq_en` in IDLE: mret completes first. The interrupt is re-evaluated in IDLE with the restored MIE.
- Synchroniser: `SYNC_STAGES` flops per line. `irq_pend` is the last stage.

## Timing
- Reset (async assert, sync-safe release) values:
  - State: IDLE.
  - All outputs 0: `stall`, `trap_valid`, `mret_valid`, `redirect`, `redirect_mret`, `trap_intr`, `trap_cause`, `trap_epc`, `trap_tval`, `irq_pend`.
  - Synchroniser flops: 0.
- All outputs are registered or decoded from state; there is no combinational input-to-output path.
- Exception at cycle N (IDLE):
  - `trap_valid` and `stall` at N+1.
  - `redirect` at N+2.
  - IDLE at N+3; fetch resumes at N+3.
- Interrupt:
  - Raw edge to `irq_pend` takes `SYNC_STAGES` cycles.
  - The DRAIN entry cycle follows; DRAIN lasts at least 1 cycle.
  - If `pipe_idle=1` on the DRAIN entry cycle, `trap_valid` is high the next cycle.
- `mret` at N: `mret_valid` at N+1, `redirect` at N+2.
- `trap_cause`/`trap_epc`/`trap_tval`/`trap_intr` are stable from the TRAP cycle until the next capture.
- Reset asserted mid-sequence forces IDLE immediately. No partial strobe is issued after reset release.

## Structure
- Shared package (`constants`):
  - `trap_state_type` enum.
  - Cause constants `cause_mei=11`, `cause_msi=3`, `cause_mti=7`.
- Shared package (`wires`):
  - `trap_ctrl_in_type`/`trap_ctrl_out_type` structs, mirroring the CSR in/out structs.
- Sub-module `irq_sync`: one parameterised N-stage synchroniser, instantiated ×3.

## Test plan
- Reset mid-DRAIN (stall=1), then release → IDLE, all outputs 0, no `trap_valid` afterwards until a new request.
- `exc_req`, cause=2, pc=0x100, tval=0xDEAD in IDLE → `trap_valid` one cycle later with cause 2, epc 0x100, tval 0xDEAD, intr=0; `redirect`=1 the next cycle with `redirect_mret`=0.
- `irq_tim`+`irq_ext` both raised, MIE=1, enables 3'b111, `pipe_idle` low for 3 cycles → `stall` held for the 3 DRAIN cycles, then trap cause 11, intr=1, epc=`next_pc`.
- During DRAIN, `exc_req` cause 5 → trap cause 5, intr=0, epc=`exc_pc`; no later interrupt trap until `irq_en` is evaluated again in IDLE.
- `mret_req` together with a pending enabled interrupt → `mret_valid`, then `redirect` with `redirect_mret`=1, then a new DRAIN for the interrupt.
- `irq_sw` pulse with MIE=0 → `irq_pend[1]`=1 after 2 cycles, no stall, no trap.
